// File: rtl/seg_score_reader_if.sv
// seg_score_reader_if
//   Bundles the multiplexed 7-segment stream and the decoded score outputs
//   of the scoreboard readback path.
//   master : the side that drives the display lines and observes scores.
//   slave  : the reader (seg_score_reader) that decodes the stream.
//   Signals:
//     seg_in    [6:0] segments {g,f,e,d,c,b,a}, active-high, a = bit0
//     dp_in           decimal point, 0 = P1 digit, 1 = P2 digit
//     p1_score  [6:0] last committed P1 score (0..99)
//     p2_score  [6:0] last committed P2 score (0..99)
//     p1_valid        one-cycle pulse on P1 score update
//     p2_valid        one-cycle pulse on P2 score update
//     frame_err       one-cycle pulse on a malformed frame
//     synced          high while the frame parser is locked to the stream
interface seg_score_reader_if;
  logic [6:0] seg_in;
  logic       dp_in;
  logic [6:0] p1_score;
  logic [6:0] p2_score;
  logic       p1_valid;
  logic       p2_valid;
  logic       frame_err;
  logic       synced;

  modport master (
    output seg_in, dp_in,
    input  p1_score, p2_score, p1_valid, p2_valid, frame_err, synced
  );

  modport slave (
    input  seg_in, dp_in,
    output p1_score, p2_score, p1_valid, p2_valid, frame_err, synced
  );
endinterface

// File: rtl/seg_score_reader.sv
// seg_score_reader
//   Reads back the time-multiplexed single-digit 7-segment stream of the
//   scoreboard: registers the lines, accepts a pattern only after it has been
//   stable for STABLE_CYCLES cycles, decodes glyphs and reassembles the
//   blank / tens / ones / blank frames into binary per-player scores.
//   Ports:
//     clk  system clock
//     rst  asynchronous reset, active-high
//     bus  seg_score_reader_if.slave (segment/dp inputs, score/status outputs)
//   Parameters:
//     STABLE_CYCLES  cycles a pattern must hold before acceptance (>= 2)
//     CNT_W          stability counter width, 2**CNT_W > STABLE_CYCLES
module seg_score_reader #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 10
) (
  input  logic                clk,
  input  logic                rst,
  seg_score_reader_if.slave   bus
);

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_WAIT_T = 2'd1;
  localparam logic [1:0] ST_WAIT_O = 2'd2;
  localparam logic [1:0] ST_WAIT_E = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  // Accept is flagged one count early so the registered pulse lands on the
  // cycle the counter reaches CNT_MAX.
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {is_digit, value}; value is 0 for non-digit patterns.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'h3F:   decode_glyph = {1'b1, 4'd0};
      7'h06:   decode_glyph = {1'b1, 4'd1};
      7'h5B:   decode_glyph = {1'b1, 4'd2};
      7'h4F:   decode_glyph = {1'b1, 4'd3};
      7'h66:   decode_glyph = {1'b1, 4'd4};
      7'h6D:   decode_glyph = {1'b1, 4'd5};
      7'h7D:   decode_glyph = {1'b1, 4'd6};
      7'h07:   decode_glyph = {1'b1, 4'd7};
      7'h7F:   decode_glyph = {1'b1, 4'd8};
      7'h6F:   decode_glyph = {1'b1, 4'd9};
      default: decode_glyph = {1'b0, 4'd0};
    endcase
  endfunction

  logic [7:0]       in_q, in_d;
  logic [7:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             dp_q, dp_d;
  logic [6:0]       p1_q, p1_d;
  logic [6:0]       p2_q, p2_d;
  logic             p1v_q, p1v_d;
  logic             p2v_q, p2v_d;
  logic             err_q, err_d;
  logic             synced_q, synced_d;

  logic [4:0]       glyph_s;
  logic             is_blank_s;
  logic             is_digit_s;
  logic [6:0]       score_s;

  // Input capture and stability filter.
  always_comb begin
    in_d   = {bus.dp_in, bus.seg_in};
    prev_d = in_q;
    if (in_q != prev_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    acc_d = (in_q == prev_q) && (cnt_q == CNT_PRE);
  end

  // While acc_q is high, prev_q still holds the pattern that earned the accept.
  assign glyph_s    = decode_glyph(prev_q[6:0]);
  assign is_blank_s = (prev_q[6:0] == 7'h00);
  assign is_digit_s = glyph_s[4];
  assign score_s    = ({3'b000, tens_q} * 7'd10) + {3'b000, ones_q};

  // Frame parser: advances only on accept pulses.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    dp_d    = dp_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p1v_d   = 1'b0;
    p2v_d   = 1'b0;
    err_d   = 1'b0;
    if (acc_q) begin
      case (state_q)
        ST_SYNC: begin
          if (is_blank_s) begin
            state_d = ST_WAIT_T;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_WAIT_T: begin
          if (is_blank_s) begin
            state_d = ST_WAIT_T;
          end else if (is_digit_s) begin
            tens_d  = glyph_s[3:0];
            dp_d    = prev_q[7];
            state_d = ST_WAIT_O;
          end else begin
            err_d   = 1'b1;
            state_d = ST_SYNC;
          end
        end
        ST_WAIT_O: begin
          if (is_blank_s) begin
            err_d   = 1'b1;
            state_d = ST_WAIT_T;
          end else if (is_digit_s && (prev_q[7] == dp_q)) begin
            ones_d  = glyph_s[3:0];
            state_d = ST_WAIT_E;
          end else begin
            err_d   = 1'b1;
            state_d = ST_SYNC;
          end
        end
        ST_WAIT_E: begin
          if (is_blank_s) begin
            if (dp_q == 1'b0) begin
              p1_d  = score_s;
              p1v_d = 1'b1;
            end else begin
              p2_d  = score_s;
              p2v_d = 1'b1;
            end
            state_d = ST_WAIT_T;
          end else begin
            err_d   = 1'b1;
            state_d = ST_SYNC;
          end
        end
        default: begin
          state_d = ST_SYNC;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    synced_d = (state_d != ST_SYNC);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q     <= 8'h00;
      prev_q   <= 8'h00;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= 1'b0;
      state_q  <= ST_SYNC;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      dp_q     <= 1'b0;
      p1_q     <= 7'd0;
      p2_q     <= 7'd0;
      p1v_q    <= 1'b0;
      p2v_q    <= 1'b0;
      err_q    <= 1'b0;
      synced_q <= 1'b0;
    end else begin
      in_q     <= in_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      state_q  <= state_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      dp_q     <= dp_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      p1v_q    <= p1v_d;
      p2v_q    <= p2v_d;
      err_q    <= err_d;
      synced_q <= synced_d;
    end
  end

  assign bus.p1_score  = p1_q;
  assign bus.p2_score  = p2_q;
  assign bus.p1_valid  = p1v_q;
  assign bus.p2_valid  = p2v_q;
  assign bus.frame_err = err_q;
  assign bus.synced    = synced_q;

endmodule

// File: tb/tb_seg_score_reader.sv
// tb_seg_score_reader
//   Drives glyph sequences into seg_score_reader (STABLE_CYCLES=4, each glyph
//   held 8 cycles) and compares pulses, scores and sync state against a
//   frame-level reference model that collects digits between blanks.
module tb_seg_score_reader;
  localparam int STABLE = 4;
  localparam int HOLD   = 8;

  logic clk = 1'b0;
  logic rst;

  seg_score_reader_if bus();

  seg_score_reader #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] dig_seg [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int checks   = 0;
  int failures = 0;

  // Cycle counter and cumulative pulse monitors.
  int cyc       = 0;
  int n_p1v     = 0;
  int n_p2v     = 0;
  int n_err     = 0;
  int n_both    = 0;
  int last_vcyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.p1_valid === 1'b1) n_p1v <= n_p1v + 1;
    if (bus.p2_valid === 1'b1) n_p2v <= n_p2v + 1;
    if (bus.frame_err === 1'b1) n_err <= n_err + 1;
    if ((bus.frame_err === 1'b1) && (bus.p1_valid === 1'b1 || bus.p2_valid === 1'b1))
      n_both <= n_both + 1;
    if (bus.p1_valid === 1'b1 || bus.p2_valid === 1'b1) last_vcyc <= cyc;
  end

  // Reference model: digits collected since the last blank.
  bit         m_sync;
  int         m_len;
  bit         m_dp;
  int         m_t, m_o;
  int         m_p1, m_p2;
  logic [7:0] last_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int seg_to_digit(input logic [6:0] s);
    int r = -1;
    for (int i = 0; i < 10; i++) if (dig_seg[i] == s) r = i;
    return r;
  endfunction

  function automatic logic [6:0] rand_invalid();
    logic [6:0] s;
    do s = 7'($urandom_range(1, 127)); while (seg_to_digit(s) >= 0);
    return s;
  endfunction

  task automatic model_reset();
    m_sync = 1'b0; m_len = 0; m_dp = 1'b0; m_t = 0; m_o = 0; m_p1 = 0; m_p2 = 0;
  endtask

  task automatic do_reset();
    bus.seg_in = 7'h49;
    bus.dp_in  = 1'b0;
    last_drv   = 8'h49;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_p1_score", bus.p1_score, 0);
    chk("rst_p2_score", bus.p2_score, 0);
    chk("rst_p1_valid", bus.p1_valid, 0);
    chk("rst_p2_valid", bus.p2_valid, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_synced", bus.synced, 0);
  endtask

  // Present one glyph for HOLD cycles and compare against the model.
  task automatic drive(input logic dp, input logic [6:0] seg);
    int s_p1, s_p2, s_err, s_both, start, d;
    int e_p1v, e_p2v, e_err;
    e_p1v = 0; e_p2v = 0; e_err = 0;
    if ({dp, seg} === last_drv) begin
      // one-cycle separator so a repeated glyph forms a new stable run
      bus.seg_in = seg ^ 7'h01;
      bus.dp_in  = ~dp;
      @(posedge clk);
      #1;
    end
    bus.seg_in = seg;
    bus.dp_in  = dp;
    last_drv   = {dp, seg};
    start  = cyc;
    s_p1   = n_p1v;
    s_p2   = n_p2v;
    s_err  = n_err;
    s_both = n_both;

    d = seg_to_digit(seg);
    if (!m_sync) begin
      if (seg == 7'h00) m_sync = 1'b1;
    end else if (seg == 7'h00) begin
      if (m_len == 2) begin
        if (m_dp == 1'b0) begin m_p1 = m_t * 10 + m_o; e_p1v = 1; end
        else begin m_p2 = m_t * 10 + m_o; e_p2v = 1; end
      end else if (m_len == 1) begin
        e_err = 1;
      end
      m_len = 0;
    end else if (d < 0) begin
      e_err = 1; m_sync = 1'b0; m_len = 0;
    end else if (m_len == 0) begin
      m_dp = dp; m_t = d; m_len = 1;
    end else if (m_len == 1 && dp == m_dp) begin
      m_o = d; m_len = 2;
    end else begin
      e_err = 1; m_sync = 1'b0; m_len = 0;
    end

    repeat (HOLD) @(posedge clk);
    #1;
    chk("p1_valid_pulses", n_p1v - s_p1, e_p1v);
    chk("p2_valid_pulses", n_p2v - s_p2, e_p2v);
    chk("frame_err_pulses", n_err - s_err, e_err);
    chk("valid_err_overlap", n_both - s_both, 0);
    chk("p1_score", bus.p1_score, m_p1);
    chk("p2_score", bus.p2_score, m_p2);
    chk("synced", bus.synced, m_sync);
    if (e_p1v + e_p2v > 0) chk("valid_latency", last_vcyc - start, STABLE + 2);
  endtask

  logic       fdp;
  int         kind, t, o;

  initial begin
    rst = 1'b1;
    bus.seg_in = 7'h00;
    bus.dp_in  = 1'b0;
    last_drv   = 8'h00;
    model_reset();

    // Reset state; a digit before any blank must not sync.
    do_reset();
    drive(1'b0, 7'h06);

    // P1 frame: 17.
    drive(1'b0, 7'h00); drive(1'b0, 7'h06); drive(1'b0, 7'h07); drive(1'b0, 7'h00);

    // P2 frame: 02.
    drive(1'b1, 7'h00); drive(1'b1, 7'h3F); drive(1'b1, 7'h5B); drive(1'b1, 7'h00);

    // Short 7F glitch between the digits is filtered out.
    drive(1'b0, 7'h00); drive(1'b0, 7'h06);
    bus.seg_in = 7'h7F; bus.dp_in = 1'b0; last_drv = 8'h7F;
    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 7'h07); drive(1'b0, 7'h00);

    // Invalid glyph mid-frame, then recovery to 99 (repeated digit).
    drive(1'b0, 7'h00); drive(1'b0, 7'h06); drive(1'b0, 7'h49); drive(1'b0, 7'h00);
    drive(1'b0, 7'h6F); drive(1'b0, 7'h6F); drive(1'b0, 7'h00);

    // Reset after a tens digit; the next frame needs a leading blank.
    drive(1'b0, 7'h00); drive(1'b0, 7'h06);
    do_reset();
    drive(1'b0, 7'h4F); drive(1'b0, 7'h66); drive(1'b0, 7'h00);
    drive(1'b0, 7'h4F); drive(1'b0, 7'h66); drive(1'b0, 7'h00);

    // Randomized frames with occasional corruption.
    for (int f = 0; f < 25; f++) begin
      fdp  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 7);
      t    = $urandom_range(0, 9);
      o    = $urandom_range(0, 9);
      drive(fdp, 7'h00);
      if (kind == 0) drive(fdp, rand_invalid());
      else drive(fdp, dig_seg[t]);
      if (kind == 1) begin
        // ones digit dropped
      end else if (kind == 2) begin
        drive(~fdp, dig_seg[o]);
      end else begin
        drive(fdp, dig_seg[o]);
      end
      if (kind == 3) drive(fdp, dig_seg[$urandom_range(0, 9)]);
    end
    drive(1'b0, 7'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
